// File: rtl/seq_stream_parser.sv
// Packet stream parser: strips the two-word header, collects the payload and
// tracks per-stream sequence continuity before handing the packet downstream.
module seq_stream_parser #(
    parameter int NUM_STREAMS       = 32,
    parameter int MAX_PAYLOAD_BYTES = 37,
    parameter int SEQ_W             = 32
) (
    input  logic                           clk,
    input  logic                           reset_b,
    input  logic [31:0]                    dataIn,
    input  logic                           dataIn_val,
    output logic                           dataIn_ready,
    input  logic                           dataIn_last,
    output logic [MAX_PAYLOAD_BYTES*8-1:0] dataOut,
    output logic [15:0]                    dataOut_bytes,
    output logic [15:0]                    dataOut_stream,
    output logic                           dataOut_val,
    input  logic                           dataOut_ready,
    output logic                           packetLost,
    output logic [SEQ_W-1:0]               seqGap,
    output logic                           formatError
);

    localparam int IDX_W = $clog2(NUM_STREAMS);
    localparam int BUF_W = MAX_PAYLOAD_BYTES * 8;

    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, COMMIT} state_t;

    state_t             state, stateNext;
    logic [15:0]        pktLen, pktStream, wordCnt;
    logic [SEQ_W-1:0]   pktSeq;
    logic               hdrErr, lastErr;
    logic [BUF_W-1:0]   prepBuf, prepBufNext;
    logic [SEQ_W-1:0]   lastSeq [NUM_STREAMS];

    logic               xfer, outFree, commitLoad, fmtErr, lost;
    logic [15:0]        payBytes, lastWordIdx;
    logic [IDX_W-1:0]   streamIdx;
    logic [SEQ_W-1:0]   expectedSeq, gap;

    assign dataIn_ready = reset_b && (state != COMMIT);
    assign xfer         = dataIn_val && dataIn_ready;
    assign outFree      = !dataOut_val || dataOut_ready;
    assign commitLoad   = (state == COMMIT) && outFree;

    assign payBytes    = (pktLen > 16'd8) ? pktLen - 16'd8 : 16'd0;
    assign lastWordIdx = ((payBytes + 16'd3) >> 2) + 16'd1;
    assign streamIdx   = pktStream[IDX_W-1:0];
    assign expectedSeq = lastSeq[streamIdx] + SEQ_W'(1);
    assign gap         = pktSeq - expectedSeq;
    assign fmtErr      = hdrErr || lastErr || (pktLen < 16'd9)
                       || (payBytes > 16'(MAX_PAYLOAD_BYTES))
                       || (pktStream >= 16'(NUM_STREAMS));
    assign lost        = !fmtErr && (pktSeq != expectedSeq);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        stateNext = state;
        case (state)
            HDR0:    if (xfer) stateNext = dataIn_last ? COMMIT : HDR1;
            HDR1:    if (xfer) stateNext = dataIn_last ? COMMIT : PAYLOAD;
            PAYLOAD: if (xfer && dataIn_last) stateNext = COMMIT;
            COMMIT:  if (outFree) stateNext = HDR0;
            default: stateNext = HDR0;
        endcase
    end

    // Byte lanes past the payload length (or past the buffer) are never written, so they stay zero.
    always_comb begin
        prepBufNext = prepBuf;
        for (int b = 0; b < MAX_PAYLOAD_BYTES; b++) begin
            if ((b / 4) == (int'(wordCnt) - 2) && b < int'(payBytes))
                prepBufNext[(MAX_PAYLOAD_BYTES-1-b)*8 +: 8] = dataIn[(3-(b%4))*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= HDR0;
            pktLen    <= '0;
            pktStream <= '0;
            pktSeq    <= '0;
            wordCnt   <= '0;
            hdrErr    <= 1'b0;
            lastErr   <= 1'b0;
            prepBuf   <= '0;
        end else begin
            state <= stateNext;
            if (xfer) begin
                case (state)
                    HDR0: begin
                        pktLen    <= dataIn[31:16];
                        pktStream <= dataIn[15:0];
                        prepBuf   <= '0;
                        wordCnt   <= 16'd1;
                        hdrErr    <= dataIn_last;
                        lastErr   <= 1'b0;
                    end
                    HDR1: begin
                        pktSeq  <= dataIn[SEQ_W-1:0];
                        wordCnt <= 16'd2;
                        hdrErr  <= dataIn_last;
                    end
                    PAYLOAD: begin
                        prepBuf <= prepBufNext;
                        if (wordCnt != 16'hFFFF) wordCnt <= wordCnt + 16'd1;
                        if (dataIn_last) lastErr <= (wordCnt != lastWordIdx);
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the sequence table is reset explicitly because a fresh stream must expect sequence 1.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            dataOut        <= '0;
            dataOut_bytes  <= '0;
            dataOut_stream <= '0;
            dataOut_val    <= 1'b0;
            packetLost     <= 1'b0;
            seqGap         <= '0;
            formatError    <= 1'b0;
            for (int i = 0; i < NUM_STREAMS; i++) lastSeq[i] <= '0;
        end else if (commitLoad) begin
            dataOut        <= prepBuf;
            dataOut_bytes  <= (payBytes > 16'(MAX_PAYLOAD_BYTES)) ? 16'(MAX_PAYLOAD_BYTES) : payBytes;
            dataOut_stream <= pktStream;
            dataOut_val    <= 1'b1;
            packetLost     <= lost;
            seqGap         <= lost ? gap : '0;
            formatError    <= fmtErr;
            if (!fmtErr) lastSeq[streamIdx] <= pktSeq;
        end else if (dataOut_val && dataOut_ready) begin
            dataOut_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_stream_parser.sv
// Directed bench for seq_stream_parser: format, sequence tracking, backpressure and reset.
module tb_seq_stream_parser;

    localparam int MAXB = 37;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic [31:0]       dataIn = '0;
    logic              dataIn_val = 1'b0;
    logic              dataIn_ready;
    logic              dataIn_last = 1'b0;
    logic [MAXB*8-1:0] dataOut;
    logic [15:0]       dataOut_bytes;
    logic [15:0]       dataOut_stream;
    logic              dataOut_val;
    logic              dataOut_ready = 1'b1;
    logic              packetLost;
    logic [31:0]       seqGap;
    logic              formatError;

    int checks = 0;
    int errors = 0;
    logic [7:0]        payload [64];
    logic [MAXB*8-1:0] heldData;

    seq_stream_parser dut (
        .clk(clk), .reset_b(reset_b),
        .dataIn(dataIn), .dataIn_val(dataIn_val), .dataIn_ready(dataIn_ready),
        .dataIn_last(dataIn_last),
        .dataOut(dataOut), .dataOut_bytes(dataOut_bytes), .dataOut_stream(dataOut_stream),
        .dataOut_val(dataOut_val), .dataOut_ready(dataOut_ready),
        .packetLost(packetLost), .seqGap(seqGap), .formatError(formatError)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [MAXB*8-1:0] topBytes(input int n);
        logic [MAXB*8-1:0] v = '0;
        for (int i = 0; i < n; i++) v[(MAXB-1-i)*8 +: 8] = payload[i];
        return v;
    endfunction

    task automatic sendWord(input logic [31:0] w, input bit last);
        int n = 0;
        @(negedge clk);
        dataIn = w; dataIn_last = last; dataIn_val = 1'b1;
        while (!dataIn_ready && n < 200) begin @(negedge clk); n++; end
        if (!dataIn_ready) chk("send_ready", dataIn_ready, 1);
        @(posedge clk); #1;
        dataIn_val = 1'b0; dataIn_last = 1'b0;
    endtask

    task automatic sendPkt(input logic [15:0] len, input logic [15:0] strm,
                           input logic [31:0] seq, input int lastWord);
        for (int w = 0; w <= lastWord; w++) begin
            if (w == 0)      sendWord({len, strm}, w == lastWord);
            else if (w == 1) sendWord(seq, w == lastWord);
            else             sendWord({payload[(w-2)*4], payload[(w-2)*4+1],
                                       payload[(w-2)*4+2], payload[(w-2)*4+3]}, w == lastWord);
        end
    endtask

    task automatic expectPkt(input string tag, input int bytesE, input int strmE,
                             input bit lostE, input logic [31:0] gapE, input bit fmtE);
        int n = 0;
        while (!dataOut_val && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, ".val"},    dataOut_val, 1);
        chk({tag, ".bytes"},  dataOut_bytes, bytesE);
        chk({tag, ".stream"}, dataOut_stream, strmE);
        chk({tag, ".lost"},   packetLost, lostE);
        chk({tag, ".gap"},    seqGap, gapE);
        chk({tag, ".fmt"},    formatError, fmtE);
        if (dataOut_ready) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) payload[i] = 8'h11;

        // Reset state
        #3;
        chk("rst.val", dataOut_val, 0);
        chk("rst.inReady", dataIn_ready, 0);
        chk("rst.data", dataOut, 0);
        chk("rst.flags", {packetLost, formatError}, 0);
        chk("rst.gap", seqGap, 0);
        @(negedge clk); reset_b = 1'b1;

        // Basic packet, 1-cycle latency and zero-filled tail
        payload[0] = 8'hAA; payload[1] = 8'hBB; payload[2] = 8'hCC;
        payload[3] = 8'hDD; payload[4] = 8'hEE;
        sendPkt(16'd13, 16'd3, 32'd1, 3);
        chk("t1.valEarly", dataOut_val, 0);
        @(posedge clk); #1;
        chk("t1.valLat", dataOut_val, 1);
        chk("t1.data", dataOut, {40'hAABBCCDDEE, 256'd0});
        expectPkt("t1", 5, 3, 0, 0, 0);
        chk("t1.valClr", dataOut_val, 0);

        // Sequence gap then resync
        sendPkt(16'd13, 16'd3, 32'd4, 3);
        expectPkt("t2gap", 5, 3, 1, 2, 0);
        sendPkt(16'd13, 16'd3, 32'd5, 3);
        expectPkt("t2ok", 5, 3, 0, 0, 0);

        // Backpressure: A held, B fully received and parked in COMMIT
        dataOut_ready = 1'b0;
        for (int i = 0; i < 8; i++) payload[i] = 8'(8'h30 + i);
        sendPkt(16'd12, 16'd5, 32'd1, 2);
        heldData = topBytes(4);
        sendPkt(16'd16, 16'd5, 32'd2, 3);
        @(posedge clk); #1;
        chk("t3.inReady", dataIn_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3.holdData", dataOut, heldData);
        chk("t3.holdBytes", dataOut_bytes, 4);
        @(negedge clk); dataOut_ready = 1'b1;
        @(posedge clk); #1;
        chk("t3.data", dataOut, topBytes(8));
        expectPkt("t3b", 8, 5, 0, 0, 0);
        chk("t3.drained", dataOut_val, 0);

        // Wrong last position leaves the stream table alone
        sendPkt(16'd9, 16'd7, 32'd1, 2);
        expectPkt("t4first", 1, 7, 0, 0, 0);
        sendPkt(16'd13, 16'd7, 32'd2, 2);
        expectPkt("t4bad", 5, 7, 0, 0, 1);
        sendPkt(16'd13, 16'd7, 32'd2, 3);
        expectPkt("t4next", 5, 7, 0, 0, 0);

        // Wrap, bad stream, oversize, short header
        sendPkt(16'd9, 16'd0, 32'hFFFF_FFFF, 2);
        expectPkt("t5first", 1, 0, 1, 32'hFFFF_FFFE, 0);
        sendPkt(16'd9, 16'd0, 32'h0000_0000, 2);
        expectPkt("t5wrap", 1, 0, 0, 0, 0);
        sendPkt(16'd9, 16'd40, 32'd1, 2);
        expectPkt("t5stream", 1, 40, 0, 0, 1);
        for (int i = 0; i < 40; i++) payload[i] = 8'(i + 1);
        sendPkt(16'd48, 16'd1, 32'd1, 11);
        @(posedge clk); #1;
        chk("t5over.data", dataOut, topBytes(37));
        expectPkt("t5over", 37, 1, 0, 0, 1);
        sendPkt(16'd8, 16'd4, 32'd1, 1);
        expectPkt("t5short", 0, 4, 0, 0, 1);

        // Reset mid-packet with a packet held
        dataOut_ready = 1'b0;
        sendPkt(16'd9, 16'd3, 32'd6, 2);
        @(posedge clk); #1;
        chk("t6.held", dataOut_val, 1);
        sendWord({16'd17, 16'd9}, 1'b0);
        sendWord(32'd1, 1'b0);
        sendWord(32'h0102_0304, 1'b0);
        @(negedge clk); reset_b = 1'b0;
        #1;
        chk("t6.rstVal", dataOut_val, 0);
        chk("t6.rstReady", dataIn_ready, 0);
        @(negedge clk); reset_b = 1'b1; dataOut_ready = 1'b1;
        sendPkt(16'd9, 16'd9, 32'd1, 2);
        expectPkt("t6s9", 1, 9, 0, 0, 0);
        sendPkt(16'd9, 16'd3, 32'd1, 2);
        expectPkt("t6s3", 1, 3, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
